// File: rtl/latch_bank_writer_pkg.sv
// Shared types and helpers for the latch bank write controller.
// Build option: WRITE_VERIFY_EN (readback verify) is handled in latch_bank_writer.
package latch_wr_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    HOLD   = 3'd3,
    VERIFY = 3'd4
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ADDR_W    = 2;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // Largest address width the one-hot helper can decode.
  localparam int ONEHOT_MAX_ADDR_W = 6;

  function automatic logic [(1 << ONEHOT_MAX_ADDR_W)-1:0] onehot(
    input logic [ONEHOT_MAX_ADDR_W-1:0] addr
  );
    onehot       = '0;
    onehot[addr] = 1'b1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/latch_bank_writer_phase_counter.sv
// Loadable down-counter with zero flag; times every phase of a write.
module phase_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Reload on state entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/latch_bank_writer.sv
// Write controller for a bank of gated D latches: drives the shared D bus,
// then pulses one registered enable with fixed setup/pulse/hold cycles.
// Build option: define WRITE_VERIFY_EN to add Q_rb/verify_err and a VERIFY
// cycle after HOLD that compares readback with the written word.
module latch_bank_writer
  import latch_wr_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [WIDTH-1:0]         in_data,
  output logic [WIDTH-1:0]         D,
  output logic [(1 << ADDR_W)-1:0] En,
  output logic                     busy
`ifdef WRITE_VERIFY_EN
  ,
  input  logic [WIDTH-1:0]         Q_rb,
  output logic                     verify_err
`endif
);

  localparam int NWORDS  = 1 << ADDR_W;
  localparam int MAX_CYC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

`ifdef WRITE_VERIFY_EN
  localparam state_t POST_HOLD = VERIFY;
`else
  localparam state_t POST_HOLD = IDLE;
`endif

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] en_addr;
  logic              accept;
  logic              load;
  logic [CNT_W-1:0]  load_val;
  logic              zero;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid && in_ready;
  // With SETUP_CYC=0 the enable rises on the accept edge, before addr_q is loaded.
  assign en_addr  = accept ? in_addr : addr_q;

  phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and counter reload; zero-length phases are skipped.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load = 1'b1;
          if (SETUP_CYC > 0) begin
            next_state = SETUP;
            load_val   = CNT_W'(SETUP_CYC - 1);
          end else begin
            next_state = PULSE;
            load_val   = CNT_W'(PULSE_CYC - 1);
          end
        end
      end
      SETUP: begin
        if (zero) begin
          next_state = PULSE;
          load       = 1'b1;
          load_val   = CNT_W'(PULSE_CYC - 1);
        end
      end
      PULSE: begin
        if (zero) begin
          if (HOLD_CYC > 0) begin
            next_state = HOLD;
            load       = 1'b1;
            load_val   = CNT_W'(HOLD_CYC - 1);
          end else begin
            next_state = POST_HOLD;
          end
        end
      end
      HOLD: begin
        if (zero) begin
          next_state = POST_HOLD;
        end
      end
      VERIFY:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture address/data on accept; enables are a registered decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      D      <= '0;
      En     <= '0;
    end else begin
      if (accept) begin
        addr_q <= in_addr;
        D      <= in_data;
      end
      En <= (next_state == PULSE) ? NWORDS'(onehot(ONEHOT_MAX_ADDR_W'(en_addr))) : '0;
    end
  end

`ifdef WRITE_VERIFY_EN
  // Readback check; D still holds the written word during VERIFY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verify_err <= 1'b0;
    end else if (accept) begin
      verify_err <= 1'b0;
    end else if (state == VERIFY) begin
      verify_err <= (Q_rb != D);
    end
  end
`endif

endmodule

// File: tb/tb_latch_bank_writer.sv
// Directed bench for latch_bank_writer with a gated-latch model of the bank.
// Build option: WRITE_VERIFY_EN enables the readback-verify checks.
`timescale 1ns/1ps
module tb_latch_bank_writer;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 2;
  localparam int NW     = 4;
  localparam int S      = 1;
  localparam int P      = 2;
  localparam int H      = 1;
`ifdef WRITE_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic              in_valid, in_ready, busy;
  logic [ADDR_W-1:0] in_addr;
  logic [WIDTH-1:0]  in_data, D;
  logic [NW-1:0]     En;

  logic              f_valid, f_ready, f_busy;
  logic [ADDR_W-1:0] f_addr;
  logic [WIDTH-1:0]  f_data, f_D;
  logic [NW-1:0]     f_En;

  logic [WIDTH-1:0]  lat [NW] = '{default: 8'h00};
  logic [ADDR_W-1:0] cur_addr = '0;
  logic              corrupt  = 1'b0;
  wr_t               sb [$];

  int vectors     = 0;
  int miscompares = 0;

`ifdef WRITE_VERIFY_EN
  logic [WIDTH-1:0] Q_rb, f_Q_rb;
  logic             verify_err, f_verify_err;
  assign Q_rb   = corrupt ? (lat[cur_addr] ^ 8'h01) : lat[cur_addr];
  assign f_Q_rb = f_D;
`endif

  always #5 clk = ~clk;

  latch_bank_writer #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .D(D), .En(En), .busy(busy)
`ifdef WRITE_VERIFY_EN
    , .Q_rb(Q_rb), .verify_err(verify_err)
`endif
  );

  latch_bank_writer #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)
  ) dut_fast (
    .clk(clk), .rst_n(rst_n), .in_valid(f_valid), .in_ready(f_ready),
    .in_addr(f_addr), .in_data(f_data), .D(f_D), .En(f_En), .busy(f_busy)
`ifdef WRITE_VERIFY_EN
    , .Q_rb(f_Q_rb), .verify_err(f_verify_err)
`endif
  );

  // Gated D latch per word: transparent while its enable is high.
  always @(D or En) begin
    for (int w = 0; w < NW; w++) begin
      if (En[w]) lat[w] = D;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus invariants: at most one enable, D frozen while an enable stays high.
  logic [WIDTH-1:0] d_prev  = '0;
  logic [NW-1:0]    en_prev = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("en_onehot0", 32'($onehot0(En)), 32'd1);
      chk("f_en_onehot0", 32'($onehot0(f_En)), 32'd1);
      if (En != '0 && en_prev != '0) chk("d_stable_under_en", 32'(D), 32'(d_prev));
      d_prev  = D;
      en_prev = En;
    end
  end

  // One write on the default-timing instance, checked cycle by cycle.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                          input bit keep, input bit bad_rb);
    int  n;
    wr_t e;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    sb.push_back(wr_t'{a, d});
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    if (!in_ready) return;
    cur_addr = a;
    corrupt  = bad_rb;
    @(posedge clk);
    #1;
    if (!keep) begin
      in_valid = 1'b0;
      in_addr  = ~a;
      in_data  = ~d;
    end
    for (int j = 1; j <= S + P + H + VER; j++) begin
      @(negedge clk);
      chk("D_during_write", 32'(D), 32'(d));
      chk("En_timing", 32'(En), ((j - 1) >= S && (j - 1) < S + P) ? 32'(4'b0001 << a) : 32'd0);
      chk("ready_busy_during", 32'({in_ready, busy}), 32'b01);
`ifdef WRITE_VERIFY_EN
      if (j == 1) chk("verify_err_clear_on_accept", 32'(verify_err), 32'd0);
`endif
    end
    @(negedge clk);
    chk("ready_back", 32'({in_ready, busy}), 32'b10);
    chk("En_idle", 32'(En), 32'd0);
    chk("D_kept_idle", 32'(D), 32'(d));
    chk("sb_size", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("latch_word", 32'(lat[e.addr]), 32'(e.data));
    end
`ifdef WRITE_VERIFY_EN
    chk("verify_err", 32'(verify_err), 32'(bad_rb));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_addr = '0; in_data = '0;
    f_valid  = 1'b0; f_addr  = '0; f_data  = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_En", 32'(En), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'({in_ready, busy}), 32'b10);

    // Reset mid-PULSE forces En and D low at once
    in_valid = 1'b1; in_addr = 2'd1; in_data = 8'h77;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (S + 1) @(negedge clk);
    chk("pulse_before_rst", 32'(En), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_En", 32'(En), 32'd0);
    chk("rst_mid_D", 32'(D), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_rst", 32'({in_ready, busy}), 32'b10);

    // Single write with default timing
    do_write(2'd2, 8'hA5, 1'b0, 1'b0);

    // in_valid held high across two writes
    do_write(2'd1, 8'h3C, 1'b1, 1'b0);
    do_write(2'd3, 8'hC3, 1'b0, 1'b0);

    // Zero setup/hold, single-cycle pulse: one write every two cycles
    f_valid = 1'b1; f_addr = 2'd2; f_data = 8'h81;
    @(posedge clk);
    #1 f_addr = 2'd1; f_data = 8'h42;
    @(negedge clk);
    chk("fast_En_1", 32'(f_En), 32'b0100);
    chk("fast_D_1", 32'(f_D), 32'h81);
    chk("fast_busy_1", 32'({f_ready, f_busy}), 32'b01);
    if (VER != 0) begin
      @(negedge clk);
      chk("fast_En_verify_1", 32'(f_En), 32'd0);
    end
    @(negedge clk);
    chk("fast_ready_1", 32'({f_ready, f_busy}), 32'b10);
    chk("fast_En_off_1", 32'(f_En), 32'd0);
    @(posedge clk);
    #1 f_valid = 1'b0;
    @(negedge clk);
    chk("fast_En_2", 32'(f_En), 32'b0010);
    chk("fast_D_2", 32'(f_D), 32'h42);
    if (VER != 0) begin
      @(negedge clk);
      chk("fast_En_verify_2", 32'(f_En), 32'd0);
    end
    @(negedge clk);
    chk("fast_ready_2", 32'({f_ready, f_busy}), 32'b10);
    chk("fast_En_off_2", 32'(f_En), 32'd0);
`ifdef WRITE_VERIFY_EN
    chk("fast_verify_err", 32'(f_verify_err), 32'd0);

    // Readback mismatch sets verify_err; held while idle; next accept clears it
    do_write(2'd0, 8'h5A, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("verify_err_held", 32'(verify_err), 32'd1);
    do_write(2'd1, 8'h66, 1'b0, 1'b0);
`endif

    // Fill the whole bank and check every word
    do_write(2'd0, 8'h11, 1'b1, 1'b0);
    do_write(2'd1, 8'h22, 1'b1, 1'b0);
    do_write(2'd2, 8'h33, 1'b1, 1'b0);
    do_write(2'd3, 8'h44, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("bank_word0", 32'(lat[0]), 32'h11);
    chk("bank_word1", 32'(lat[1]), 32'h22);
    chk("bank_word2", 32'(lat[2]), 32'h33);
    chk("bank_word3", 32'(lat[3]), 32'h44);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
